// File: rtl/vx_dispatch_pkg.sv
// Shared types and width helpers for the dispatch scheduler.
// Struct fields are sized for the largest supported config; modules use the low bits.
package vx_dispatch_pkg;

   localparam int unsigned MAX_NC_W = 8;
   localparam int unsigned MAX_RQ_W = 8;

   function automatic int unsigned calc_id_w(input int unsigned num_ids);
      return (num_ids > 1) ? $clog2(num_ids) : 1;
   endfunction

   function automatic int unsigned calc_nc_w(input int unsigned num_cores);
      return (num_cores > 1) ? $clog2(num_cores) : 1;
   endfunction

   function automatic int unsigned calc_rq_w(input int unsigned num_reqs);
      return (num_reqs > 1) ? $clog2(num_reqs) : 1;
   endfunction

   typedef struct packed {
      logic [MAX_NC_W-1:0] core_id;
      logic [MAX_NC_W-1:0] size_m1;
   } dispatch_req_t;

   typedef struct packed {
      logic                busy;
      logic [MAX_NC_W:0]   pending;
      logic [MAX_RQ_W-1:0] owner;
   } entry_t;

endpackage

// File: rtl/vx_dispatch_id_table.sv
// Outstanding-dispatch table: lowest-free ID allocation, per-core completion
// counting and a registered one-cycle completion response.
module vx_dispatch_id_table
   import vx_dispatch_pkg::*;
#(
   parameter int unsigned NUM_IDS = 8,
   parameter int unsigned ID_W    = 3,
   parameter int unsigned NC_W    = 2,
   parameter int unsigned RQ_W    = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            alloc,
   input  logic [NC_W-1:0] alloc_size_m1,
   input  logic [RQ_W-1:0] alloc_owner,
   input  logic            done_valid,
   input  logic [ID_W-1:0] done_id,
   output logic [ID_W-1:0] alloc_id,
   output logic            full,
   output logic            stray_done,
   output logic            rsp_valid,
   output logic [ID_W-1:0] rsp_id,
   output logic [RQ_W-1:0] rsp_owner
);

   localparam int unsigned PW = MAX_NC_W + 1;

   entry_t     tbl_q [NUM_IDS];
   logic       any_free;
   logic       done_hit;
   logic       done_last;
   entry_t     done_entry;

   always_comb begin
      alloc_id = '0;
      any_free = 1'b0;
      for (int i = NUM_IDS - 1; i >= 0; i--) begin
         if (!tbl_q[i].busy) begin
            any_free = 1'b1;
            alloc_id = ID_W'(i);
         end
      end
   end

   assign full       = ~any_free;
   assign done_entry = tbl_q[done_id];
   assign done_hit   = done_valid & done_entry.busy;
   assign done_last  = done_hit & (done_entry.pending == PW'(1));
   assign stray_done = done_valid & ~done_entry.busy;

   // alloc only targets FREE entries and done_hit only BUSY ones, so they never collide
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_IDS; i++) begin
            tbl_q[i] <= '0;
         end
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_owner <= '0;
      end else begin
         rsp_valid <= 1'b0;
         if (alloc) begin
            tbl_q[alloc_id].busy    <= 1'b1;
            tbl_q[alloc_id].pending <= PW'(alloc_size_m1) + PW'(1);
            tbl_q[alloc_id].owner   <= MAX_RQ_W'(alloc_owner);
         end
         if (done_last) begin
            tbl_q[done_id].busy    <= 1'b0;
            tbl_q[done_id].pending <= '0;
            rsp_valid              <= 1'b1;
            rsp_id                 <= done_id;
            rsp_owner              <= done_entry.owner[RQ_W-1:0];
         end else if (done_hit) begin
            tbl_q[done_id].pending <= done_entry.pending - PW'(1);
         end
      end
   end

endmodule

// File: rtl/vx_dispatch_sched.sv
// Round-robin dispatch scheduler with ID allocation and completion tracking.
// Optional performance counters enabled by VX_DISPATCH_SCHED_PERF_EN.
module vx_dispatch_sched
   import vx_dispatch_pkg::*;
#(
   parameter int unsigned NUM_REQS  = 4,
   parameter int unsigned NUM_IDS   = 8,
   parameter int unsigned NUM_CORES = 4,
   localparam int unsigned ID_W     = calc_id_w(NUM_IDS),
   localparam int unsigned NC_W     = calc_nc_w(NUM_CORES),
   localparam int unsigned RQ_W     = calc_rq_w(NUM_REQS)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQS-1:0]            req_valid,
   input  logic [NUM_REQS-1:0][NC_W-1:0]  req_size_m1,
   input  logic [NUM_REQS-1:0][NC_W-1:0]  req_core_id,
   output logic [NUM_REQS-1:0]            req_ready,
   output logic                           out_valid,
   output logic [ID_W-1:0]                out_id,
   output logic [NC_W-1:0]                out_size_m1,
   output logic [NC_W-1:0]                out_core_id,
   input  logic                           out_ready,
   input  logic                           done_valid,
   input  logic [ID_W-1:0]                done_id,
   output logic                           rsp_valid,
   output logic [ID_W-1:0]                rsp_id,
   output logic [RQ_W-1:0]                rsp_owner,
   output logic                           full
`ifdef VX_DISPATCH_SCHED_PERF_EN
   ,
   output logic [31:0]                    perf_stall_full,
   output logic [31:0]                    perf_stray_done
`endif
);

   logic [RQ_W-1:0]     rr_ptr;
   logic [NUM_REQS-1:0] grant;
   logic [RQ_W-1:0]     grant_idx;
   logic                found;
   logic                fire;
   logic                stray_done;
   dispatch_req_t       reqs [NUM_REQS];
   dispatch_req_t       sel;

   always_comb begin
      for (int i = 0; i < NUM_REQS; i++) begin
         reqs[i].core_id = MAX_NC_W'(req_core_id[i]);
         reqs[i].size_m1 = MAX_NC_W'(req_size_m1[i]);
      end
   end

   // Search starts at rr_ptr and wraps; no grant at all while the table is full.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      for (int k = 0; k < NUM_REQS; k++) begin
         int idx;
         idx = (int'(rr_ptr) + k) % NUM_REQS;
         if (!found && !full && req_valid[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = RQ_W'(idx);
         end
      end
   end

   assign sel         = reqs[grant_idx];
   assign out_valid   = |grant;
   assign out_size_m1 = sel.size_m1[NC_W-1:0];
   assign out_core_id = sel.core_id[NC_W-1:0];
   assign req_ready   = grant & {NUM_REQS{out_ready}};
   assign fire        = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr <= '0;
      end else if (fire) begin
         rr_ptr <= (int'(grant_idx) == NUM_REQS - 1) ? '0 : grant_idx + RQ_W'(1);
      end
   end

   vx_dispatch_id_table #(
      .NUM_IDS (NUM_IDS),
      .ID_W    (ID_W),
      .NC_W    (NC_W),
      .RQ_W    (RQ_W)
   ) u_id_table (
      .clk           (clk),
      .reset         (reset),
      .alloc         (fire),
      .alloc_size_m1 (out_size_m1),
      .alloc_owner   (grant_idx),
      .done_valid    (done_valid),
      .done_id       (done_id),
      .alloc_id      (out_id),
      .full          (full),
      .stray_done    (stray_done),
      .rsp_valid     (rsp_valid),
      .rsp_id        (rsp_id),
      .rsp_owner     (rsp_owner)
   );

`ifdef VX_DISPATCH_SCHED_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_stall_full <= '0;
         perf_stray_done <= '0;
      end else begin
         if ((|req_valid) && full && (perf_stall_full != '1)) begin
            perf_stall_full <= perf_stall_full + 32'd1;
         end
         if (stray_done && (perf_stray_done != '1)) begin
            perf_stray_done <= perf_stray_done + 32'd1;
         end
      end
   end
`else
   logic unused_stray;
   assign unused_stray = stray_done;
`endif

endmodule

// File: tb/tb_vx_dispatch_sched.sv
// Directed self-checking bench for vx_dispatch_sched (default parameters).
module tb_vx_dispatch_sched;

   logic            clk;
   logic            reset;
   logic [3:0]      req_valid;
   logic [3:0][1:0] req_size_m1;
   logic [3:0][1:0] req_core_id;
   logic [3:0]      req_ready;
   logic            out_valid;
   logic [2:0]      out_id;
   logic [1:0]      out_size_m1;
   logic [1:0]      out_core_id;
   logic            out_ready;
   logic            done_valid;
   logic [2:0]      done_id;
   logic            rsp_valid;
   logic [2:0]      rsp_id;
   logic [1:0]      rsp_owner;
   logic            full;
`ifdef VX_DISPATCH_SCHED_PERF_EN
   logic [31:0]     perf_stall_full;
   logic [31:0]     perf_stray_done;
`endif

   int checks = 0;
   int errors = 0;

   vx_dispatch_sched #(
      .NUM_REQS  (4),
      .NUM_IDS   (8),
      .NUM_CORES (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_size_m1 (req_size_m1),
      .req_core_id (req_core_id),
      .req_ready   (req_ready),
      .out_valid   (out_valid),
      .out_id      (out_id),
      .out_size_m1 (out_size_m1),
      .out_core_id (out_core_id),
      .out_ready   (out_ready),
      .done_valid  (done_valid),
      .done_id     (done_id),
      .rsp_valid   (rsp_valid),
      .rsp_id      (rsp_id),
      .rsp_owner   (rsp_owner),
      .full        (full)
`ifdef VX_DISPATCH_SCHED_PERF_EN
      ,
      .perf_stall_full (perf_stall_full),
      .perf_stray_done (perf_stray_done)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req_valid  = '0;
      out_ready  = 1'b1;
      done_valid = 1'b0;
      done_id    = '0;
      reset      = 1'b1;
      step();
      reset      = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      req_size_m1 = '0;
      req_core_id = '0;
      do_reset();
      checks++;
      if (full !== 1'b0) begin
         errors++; $display("FAIL reset_full got %0b want 0", full);
      end
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++; $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid);
      end
      checks++;
      if (out_valid !== 1'b0 || req_ready !== 4'b0000) begin
         errors++; $display("FAIL reset_idle got out_valid=%0b ready=%b want 0/0000",
                            out_valid, req_ready);
      end
   endtask

   task automatic test_single();
      do_reset();
      req_valid      = 4'b0001;
      req_size_m1[0] = 2'd3;
      req_core_id[0] = 2'd0;
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_id !== 3'd0 || req_ready !== 4'b0001 ||
          out_size_m1 !== 2'd3) begin
         errors++;
         $display("FAIL single_issue got v=%0b id=%0d rdy=%b sz=%0d want 1/0/0001/3",
                  out_valid, out_id, req_ready, out_size_m1);
      end
      step();
      req_valid  = '0;
      done_valid = 1'b1;
      done_id    = 3'd0;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (rsp_valid !== (i == 3)) begin
            errors++; $display("FAIL single_rsp_timing done#%0d got %0b want %0b",
                               i, rsp_valid, (i == 3));
         end
      end
      done_valid = 1'b0;
      checks++;
      if (rsp_id !== 3'd0 || rsp_owner !== 2'd0) begin
         errors++; $display("FAIL single_rsp_fields got id=%0d own=%0d want 0/0",
                            rsp_id, rsp_owner);
      end
      step();
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++; $display("FAIL single_rsp_pulse got %0b want 0", rsp_valid);
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         req_core_id[i] = 2'(i);
         req_size_m1[i] = 2'd0;
      end
      req_valid = 4'b1111;
      #1;
      for (int k = 0; k < 5; k++) begin
         logic [3:0] exp_rdy;
         exp_rdy = 4'b0001 << (k % 4);
         checks++;
         if (req_ready !== exp_rdy || out_id !== 3'(k) || out_core_id !== 2'(k % 4)) begin
            errors++;
            $display("FAIL rr_grant%0d got rdy=%b id=%0d core=%0d want %b/%0d/%0d",
                     k, req_ready, out_id, out_core_id, exp_rdy, k, k % 4);
         end
         step();
      end
      req_valid = '0;
   endtask

   task automatic test_full();
      do_reset();
      req_valid      = 4'b0001;
      req_size_m1[0] = 2'd0;
      for (int k = 0; k < 8; k++) step();
      checks++;
      if (full !== 1'b1 || out_valid !== 1'b0 || req_ready !== 4'b0000) begin
         errors++; $display("FAIL full_block got full=%0b v=%0b rdy=%b want 1/0/0000",
                            full, out_valid, req_ready);
      end
      done_valid = 1'b1;
      done_id    = 3'd5;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL full_no_bypass got out_valid=%0b want 0", out_valid);
      end
      step();
      done_valid = 1'b0;
      #1;
      checks++;
      if (full !== 1'b0 || out_valid !== 1'b1 || out_id !== 3'd5) begin
         errors++; $display("FAIL full_reuse got full=%0b v=%0b id=%0d want 0/1/5",
                            full, out_valid, out_id);
      end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 3'd5 || rsp_owner !== 2'd0) begin
         errors++; $display("FAIL full_rsp got v=%0b id=%0d own=%0d want 1/5/0",
                            rsp_valid, rsp_id, rsp_owner);
      end
`ifdef VX_DISPATCH_SCHED_PERF_EN
      checks++;
      if (perf_stall_full !== 32'd1) begin
         errors++; $display("FAIL perf_stall_full got %0d want 1", perf_stall_full);
      end
`endif
      step();
      req_valid = '0;
      #1;
      checks++;
      if (full !== 1'b1) begin
         errors++; $display("FAIL full_refill got %0b want 1", full);
      end
   endtask

   task automatic test_stray_done();
      do_reset();
      done_valid = 1'b1;
      done_id    = 3'd2;
      step();
      done_valid = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++; $display("FAIL stray_rsp got %0b want 0", rsp_valid);
      end
`ifdef VX_DISPATCH_SCHED_PERF_EN
      checks++;
      if (perf_stray_done !== 32'd1) begin
         errors++; $display("FAIL perf_stray_done got %0d want 1", perf_stray_done);
      end
`endif
      req_valid = 4'b0001;
      #1;
      checks++;
      if (out_id !== 3'd0 || full !== 1'b0) begin
         errors++; $display("FAIL stray_state got id=%0d full=%0b want 0/0", out_id, full);
      end
      req_valid = '0;
   endtask

   task automatic test_backpressure();
      do_reset();
      req_valid      = 4'b0010;
      req_size_m1[1] = 2'd0;
      out_ready      = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (req_ready !== 4'b0000 || out_valid !== 1'b1 || out_id !== 3'd0) begin
            errors++; $display("FAIL bp_stall%0d got rdy=%b v=%0b id=%0d want 0000/1/0",
                               k, req_ready, out_valid, out_id);
         end
         step();
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0010 || out_id !== 3'd0) begin
         errors++; $display("FAIL bp_release got rdy=%b id=%0d want 0010/0", req_ready, out_id);
      end
      step();
      #1;
      checks++;
      if (out_id !== 3'd1) begin
         errors++; $display("FAIL bp_once got next id=%0d want 1", out_id);
      end
      req_valid  = '0;
      done_valid = 1'b1;
      done_id    = 3'd0;
      step();
      done_valid = 1'b0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 3'd0 || rsp_owner !== 2'd1) begin
         errors++; $display("FAIL bp_owner got v=%0b id=%0d own=%0d want 1/0/1",
                            rsp_valid, rsp_id, rsp_owner);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      req_valid = 4'b0100;
      req_size_m1[2] = 2'd1;
      for (int k = 0; k < 3; k++) step();
      req_valid  = '0;
      done_valid = 1'b1;
      done_id    = 3'd0;
      step();
      reset      = 1'b1;
      step();
      reset      = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || full !== 1'b0) begin
         errors++; $display("FAIL rst_mid_state got rsp=%0b full=%0b want 0/0", rsp_valid, full);
      end
      req_valid = 4'b1111;
      #1;
      checks++;
      if (out_id !== 3'd0 || req_ready !== 4'b0001) begin
         errors++; $display("FAIL rst_mid_alloc got id=%0d rdy=%b want 0/0001", out_id, req_ready);
      end
      done_valid = 1'b0;
      req_valid  = '0;
      done_valid = 1'b1;
      done_id    = 3'd1;
      step();
      done_valid = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++; $display("FAIL rst_mid_stray got rsp=%0b want 0", rsp_valid);
      end
   endtask

   initial begin
      reset       = 1'b1;
      req_valid   = '0;
      req_size_m1 = '0;
      req_core_id = '0;
      out_ready   = 1'b0;
      done_valid  = 1'b0;
      done_id     = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_full();
      test_stray_done();
      test_backpressure();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vx_dispatch_sched.md
Name: vx_dispatch_sched

Overview:
Schedules dispatch requests from NUM_REQS requesters onto one downstream dispatch port.
- Arbitrates round-robin between requesters.
- Allocates a dispatch ID from a table of outstanding dispatches.
- Counts per-core completions against each ID.
- Broadcasts a registered response carrying ID and owner once every core of a dispatch has finished.
- Sits between the per-cluster dispatch requesters and the dispatch arbitration/broadcast network.

Parameters:
NUM_REQS, 4, number of requesters (>=1)
NUM_IDS, 8, outstanding dispatch table depth (power of 2, >=2)
NUM_CORES, 4, cores addressable per dispatch (>=2)
(derived) ID_W = clog2(NUM_IDS); NC_W = clog2(NUM_CORES); RQ_W = max(1, clog2(NUM_REQS))

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  NUM_REQS  requester i has a dispatch request
req_size_m1  in  NUM_REQS x NC_W  number of cores minus one
req_core_id  in  NUM_REQS x NC_W  base core
req_ready  out  NUM_REQS  request accepted
out_valid  out  1  dispatch issued downstream
out_id  out  ID_W  allocated dispatch ID
out_size_m1  out  NC_W  forwarded size
out_core_id  out  NC_W  forwarded base core
out_ready  in  1  downstream accepts
done_valid  in  1  one core finished a dispatch
done_id  in  ID_W  ID of finished dispatch
rsp_valid  out  1  dispatch fully complete
rsp_id  out  ID_W  completed ID
rsp_owner  out  RQ_W  requester that issued it
full  out  1  no free ID

Behaviour:
- Clock is clk; reset is synchronous, active-high (decided). On reset: all entries FREE, rr pointer 0, rsp_valid=0, full=0. rsp_id and rsp_owner are don't-care. Reset mid-operation discards all outstanding dispatches; completions arriving afterward are treated as stray.
- Entry state is per ID: FREE or BUSY, with pending count (NC_W+1 bits) and owner (RQ_W bits).
- Allocation: alloc_id = lowest-index FREE entry. full = no FREE entry (combinational from registered state).
- Arbitration:
  - Round-robin, starting from the rr pointer.
  - grant is combinational among req_valid, masked to zero when full.
  - out_valid = |grant. out_* fields come from the granted requester; out_id = alloc_id.
  - req_ready[i] = grant[i] & out_ready.
- Handshake (out_valid & out_ready), effective next edge:
  - entry[alloc_id] <= BUSY, pending = size_m1+1, owner = granted index.
  - rr pointer <= granted index + 1, modulo NUM_REQS.
  - Zero-latency pass-through: request to out_valid in the same cycle.
- No stall on out_valid: the grant may change while out_ready=0. Requesters must hold req_valid and their data until req_ready.
- Completion: done_valid to a BUSY entry decrements pending. When pending goes 1->0, the entry becomes FREE at the edge, and rsp_valid=1 with rsp_id/rsp_owner is registered the same edge (1-cycle latency from the final done). rsp_valid lasts exactly one cycle; there is no backpressure.
- done_valid to a FREE entry is ignored; state is unchanged.
- Simultaneous allocation and completion in one cycle cannot target the same ID, since alloc targets a FREE entry and done targets a BUSY one. An ID freed this cycle is allocatable only from the next cycle; there is no bypass.
- Full boundary: with all IDs BUSY, req_ready=0 and out_valid=0 until a completion frees an entry.
- Width: pending holds values up to NUM_CORES; size_m1+1 is computed in NC_W+1 bits without overflow.

Optional Feature:
VX_DISPATCH_SCHED_PERF_EN
- Defined:
  - adds outputs perf_stall_full (32b): cycles with any req_valid while full.
  - adds perf_stray_done (32b): done_valid to a FREE entry.
  - Both counters reset to 0 and saturate at all-ones.
- Undefined: the ports and counters are absent. Functional behaviour is identical.

Decomposition:
- Shared package vx_dispatch_pkg:
  - dispatch_req_t struct {core_id, size_m1}
  - entry_t struct {busy, pending, owner}
  - ID_W and NC_W helper functions
- One sub-module, vx_dispatch_id_table: holds the FREE/BUSY array, lowest-free allocation, decrement/free logic, and rsp registering. The top holds the round-robin arbiter and handshake glue.

Test Plan:
- Reset, then req 0 valid with size_m1=3, core_id=0, out_ready=1 -> same cycle out_valid=1, out_id=0, req_ready[0]=1. Four done_valid with id 0 -> rsp_valid one cycle after the fourth, rsp_id=0, rsp_owner=0.
- Reqs 0-3 valid continuously, out_ready=1 -> grants in order 0,1,2,3,0 with out_id 0,1,2,3,4.
- Issue 8 dispatches without completing any -> full=1, out_valid=0. Next cycle, done to id 5 with size_m1=0 -> following cycle full=0 and the next allocation gets out_id=5.
- done_valid id 2 while entry 2 is FREE -> no rsp, state unchanged; with PERF_EN, perf_stray_done=1.
- out_ready=0 for 3 cycles with req 1 valid -> table unchanged, req_ready=0. Then out_ready=1 -> allocation happens once only.
- Assert reset with 3 BUSY entries -> next cycle all FREE, rsp_valid=0, next out_id=0, rr pointer 0.
